// File: rtl/barrett_final_sub.sv
// Barrett final correction: subtracts M from r (at most twice) until r < M,
// using a digit-serial LSB-first borrow chain of D bits per cycle.

module barrett_digit_sub #(
  parameter int D = 4
) (
  input  logic [D-1:0] a,
  input  logic [D-1:0] b,
  input  logic         bin,
  output logic [D-1:0] d,
  output logic         bout
);
  always_comb begin
    {bout, d} = {1'b0, a} - {1'b0, b} - {{D{1'b0}}, bin};
  end
endmodule

module barrett_final_sub #(
  parameter int N = 16,
  parameter int D = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N+1:0] r_in,
  input  logic [N-1:0] m_in,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic [1:0]   sub_cnt,
  output logic         err
);
  localparam int P  = (N + 2 + D - 1) / D;
  localparam int W  = P * D;
  localparam int KW = (P > 1) ? $clog2(P) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SUB   = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state;
  logic [W-1:0]  r_q, m_q, diff_q;
  logic          borrow;
  logic [KW-1:0] k;
  logic [D-1:0]  r_dig, m_dig, d_dig;
  logic          b_out;

  assign r_dig = r_q[k*D +: D];
  assign m_dig = m_q[k*D +: D];

  barrett_digit_sub #(.D(D)) u_dsub (
    .a    (r_dig),
    .b    (m_dig),
    .bin  (borrow),
    .d    (d_dig),
    .bout (b_out)
  );

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      r_q     <= '0;
      m_q     <= '0;
      diff_q  <= '0;
      borrow  <= 1'b0;
      k       <= '0;
      result  <= '0;
      sub_cnt <= '0;
      err     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          r_q     <= W'(r_in);
          m_q     <= W'(m_in);
          sub_cnt <= '0;
          err     <= 1'b0;
          borrow  <= 1'b0;
          k       <= '0;
          state   <= S_SUB;
        end
        S_SUB: begin
          // r_q is left untouched; the difference is only committed in CHECK
          diff_q[k*D +: D] <= d_dig;
          borrow           <= b_out;
          k                <= k + 1'b1;
          if (k == KW'(P - 1)) state <= S_CHECK;
        end
        S_CHECK: begin
          if (borrow) begin
            result <= r_q[N-1:0];
            state  <= S_DONE;
          end else if (sub_cnt != 2'd2) begin
            r_q     <= diff_q;
            sub_cnt <= sub_cnt + 2'd1;
            borrow  <= 1'b0;
            k       <= '0;
            state   <= S_SUB;
          end else begin
            err    <= 1'b1;
            result <= r_q[N-1:0];
            state  <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
